// File: rtl/latch_wr_arbiter_if.sv
// latch_wr_arbiter_if: requester/latch-bank bundle for latch_wr_arbiter.
// master = requester side (req, req_addr, req_data); slave = arbiter side.
interface latch_wr_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int NLATCH = 4,
  parameter int DW     = 8
);
  localparam int AW = (NLATCH > 1) ? $clog2(NLATCH) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [DW-1:0]      lat_d;
  logic [NLATCH-1:0]  lat_en;

  modport master (
    output req, req_addr, req_data,
    input  gnt, busy, lat_d, lat_en
  );

  modport slave (
    input  req, req_addr, req_data,
    output gnt, busy, lat_d, lat_en
  );
endinterface

// File: rtl/latch_wr_arbiter.sv
// latch_wr_arbiter: round-robin writer into a shared bank of D/EN latches.
// Ports: clk, rst_n (async low), bus (slave: req/addr/data in; gnt/busy/lat_d/lat_en out).
// Macro LATCH_WR_ARBITER_FIXED_PRIO_EN: lowest req index wins, no rr pointer.
module latch_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int NLATCH    = 4,
  parameter int DW        = 8,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic clk,
  input  logic rst_n,
  latch_wr_arbiter_if.slave bus
);
  localparam int AW   = (NLATCH > 1) ? $clog2(NLATCH) : 1;
  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE, SETUP, PULSE, HOLD
  } state_e;

  state_e state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;

  logic [IW-1:0] start;
  logic [IW-1:0] idx;
  logic [IW-1:0] win_n;
  logic          hit;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  logic [IW-1:0]     win_q;
  logic [AW-1:0]     addr_q;
  logic [NREQ-1:0]   gnt_q, gnt_n;
  logic              busy_q, busy_n;
  logic [DW-1:0]     lat_d_q, lat_d_n;
  logic [NLATCH-1:0] lat_en_q, lat_en_n;

  logic last_pulse, last_hold;
  assign last_pulse = (cnt_q == CW'(PULSE_CYC - 1));
  assign last_hold  = (cnt_q == CW'(GAP_CYC - 1));

`ifdef LATCH_WR_ARBITER_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IW-1:0] rr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else if (state_q == HOLD && last_hold) begin
      rr_q <= (int'(win_q) == NREQ - 1) ? '0 : win_q + IW'(1);
    end
  end

  assign start = rr_q;
`endif

  // First requester found walking up from start, wrapping at NREQ.
  always_comb begin
    hit   = 1'b0;
    win_n = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(start) + k) % NREQ);
      if (!hit && bus.req[idx]) begin
        hit   = 1'b1;
        win_n = idx;
      end
    end
  end

  assign win_addr = bus.req_addr[win_n*AW +: AW];
  assign win_data = bus.req_data[win_n*DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_n = SETUP;
          cnt_n   = '0;
        end
      end
      SETUP: begin
        state_n = PULSE;
        cnt_n   = '0;
      end
      PULSE: begin
        if (last_pulse) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (last_hold) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state and registered, so every
  // output is a flop and lat_en lines up exactly with the PULSE window.
  always_comb begin
    busy_n   = (state_n != IDLE);
    lat_d_n  = lat_d_q;
    lat_en_n = '0;
    gnt_n    = '0;
    if (state_q == IDLE && hit) begin
      lat_d_n = win_data;
    end
    if (state_n == PULSE && int'(addr_q) < NLATCH) begin
      lat_en_n[addr_q] = 1'b1;
    end
    if (state_n == HOLD && cnt_n == CW'(GAP_CYC - 1)) begin
      gnt_n[win_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q    <= '0;
      addr_q   <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
    end else begin
      if (state_q == IDLE && hit) begin
        win_q  <= win_n;
        addr_q <= win_addr;
      end
      gnt_q    <= gnt_n;
      busy_q   <= busy_n;
      lat_d_q  <= lat_d_n;
      lat_en_q <= lat_en_n;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.busy   = busy_q;
  assign bus.lat_d  = lat_d_q;
  assign bus.lat_en = lat_en_q;

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// tb_latch_wr_arbiter: directed bench for latch_wr_arbiter.
// u_dut uses defaults; u_dut2 uses NLATCH=3, PULSE_CYC=1, GAP_CYC=3.
module tb_latch_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  latch_wr_arbiter_if #(.NREQ(4), .NLATCH(4), .DW(8)) bus ();
  latch_wr_arbiter_if #(.NREQ(4), .NLATCH(3), .DW(8)) bus2 ();

  latch_wr_arbiter #(
    .NREQ(4), .NLATCH(4), .DW(8), .PULSE_CYC(2), .GAP_CYC(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  latch_wr_arbiter #(
    .NREQ(4), .NLATCH(3), .DW(8), .PULSE_CYC(1), .GAP_CYC(3)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int exp_gnt[3];
  int last;
  int n;
  logic [3:0] prev_en;
  logic [7:0] prev_d;

  initial begin
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus2.req = '0;
    bus2.req_addr = '0;
    bus2.req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_gnt", bus.gnt, 0);
    check("rst_en", bus.lat_en, 0);
    check("rst_d", bus.lat_d, 0);
    rst_n = 1'b1;
    tick();

    // single write: req[2], addr 3, data A5
    bus.req = 4'b0100;
    bus.req_addr[4 +: 2] = 2'd3;
    bus.req_data[16 +: 8] = 8'hA5;
    tick();
    check("t1_c1_d", bus.lat_d, 8'hA5);
    check("t1_c1_en", bus.lat_en, 0);
    check("t1_c1_busy", bus.busy, 1);
    bus.req = '0;
    tick();
    check("t1_c2_en", bus.lat_en, 4'b1000);
    tick();
    check("t1_c3_en", bus.lat_en, 4'b1000);
    check("t1_c3_gnt", bus.gnt, 0);
    tick();
    check("t1_c4_en", bus.lat_en, 0);
    check("t1_c4_gnt", bus.gnt, 4'b0100);
    check("t1_c4_busy", bus.busy, 1);
    tick();
    check("t1_c5_gnt", bus.gnt, 0);
    check("t1_c5_busy", bus.busy, 0);
    check("t1_c5_d", bus.lat_d, 8'hA5);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // all four requesting, each drops after its grant
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*2 +: 2] = 2'(i);
      bus.req_data[i*8 +: 8] = 8'(8'h10 + i);
    end
    bus.req = 4'b1111;
    n = 0;
    last = 0;
    prev_en = '0;
    prev_d = '0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      tick();
      check("t2_onehot", 32'($countones(bus.lat_en) <= 1), 1);
      if (prev_en != 0 && bus.lat_en != 0)
        check("t2_dstable", bus.lat_d, prev_d);
      if (bus.gnt != 0) begin
        check("t2_gnt", bus.gnt, 32'(1) << n);
        check("t2_gap", c - last, (n == 0) ? 4 : 5);
        check("t2_d", bus.lat_d, 32'(8'h10 + n));
        bus.req = bus.req & ~bus.gnt;
        last = c;
        n++;
      end
      prev_en = bus.lat_en;
      prev_d = bus.lat_d;
    end
    check("t2_count", n, 4);
    tick();

    // captured data immune to later req_data changes
    bus.req_addr[2 +: 2] = 2'd0;
    bus.req_data[8 +: 8] = 8'h3C;
    bus.req = 4'b0010;
    tick();
    check("t3_c1_d", bus.lat_d, 8'h3C);
    bus.req = '0;
    tick();
    check("t3_c2_en", bus.lat_en, 4'b0001);
    bus.req_data[8 +: 8] = 8'hFF;
    tick();
    check("t3_c3_d", bus.lat_d, 8'h3C);
    tick();
    check("t3_c4_gnt", bus.gnt, 4'b0010);
    check("t3_c4_d", bus.lat_d, 8'h3C);
    tick();
    check("t3_c5_d", bus.lat_d, 8'h3C);
    check("t3_c5_busy", bus.busy, 0);

    // reset during PULSE, then arbitration restarts from pointer 0
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    tick();
    check("t4_pulse_en", bus.lat_en, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("t4_rst_en", bus.lat_en, 0);
    check("t4_rst_busy", bus.busy, 0);
    tick();
    check("t4_rst_gnt0", bus.gnt, 0);
    tick();
    check("t4_rst_gnt1", bus.gnt, 0);
    rst_n = 1'b1;
`ifdef LATCH_WR_ARBITER_FIXED_PRIO_EN
    exp_gnt = '{1, 1, 1};
`else
    exp_gnt = '{1, 3, 1};
`endif
    bus.req = 4'b1010;
    n = 0;
    last = 0;
    for (int c = 1; c <= 40 && n < 3; c++) begin
      tick();
      if (bus.gnt != 0) begin
        check("t4_gnt", bus.gnt, 32'(1) << exp_gnt[n]);
        check("t4_gap", c - last, (n == 0) ? 4 : 5);
        last = c;
        n++;
      end
    end
    check("t4_count", n, 3);
    bus.req = '0;
    repeat (6) tick();

    // second build: PULSE_CYC=1, GAP_CYC=3
    bus2.req_addr[0 +: 2] = 2'd1;
    bus2.req_data[0 +: 8] = 8'h5A;
    bus2.req = 4'b0001;
    tick();
    check("t5_c1_d", bus2.lat_d, 8'h5A);
    check("t5_c1_en", bus2.lat_en, 0);
    bus2.req = '0;
    tick();
    check("t5_c2_en", bus2.lat_en, 3'b010);
    check("t5_c2_d", bus2.lat_d, 8'h5A);
    tick();
    check("t5_c3_en", bus2.lat_en, 0);
    check("t5_c3_d", bus2.lat_d, 8'h5A);
    tick();
    check("t5_c4_gnt", bus2.gnt, 0);
    check("t5_c4_d", bus2.lat_d, 8'h5A);
    tick();
    check("t5_c5_gnt", bus2.gnt, 4'b0001);
    check("t5_c5_d", bus2.lat_d, 8'h5A);
    check("t5_c5_busy", bus2.busy, 1);
    tick();
    check("t5_c6_gnt", bus2.gnt, 0);
    check("t5_c6_busy", bus2.busy, 0);

    // address beyond a 3-latch bank: no enable, grant still issued
    bus2.req_addr[0 +: 2] = 2'd3;
    bus2.req_data[0 +: 8] = 8'hC3;
    bus2.req = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) bus2.req = '0;
      check("t6_en", bus2.lat_en, 0);
      if (c == 5) check("t6_gnt", bus2.gnt, 4'b0001);
    end
    tick();
    check("t6_d", bus2.lat_d, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
